dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
Sequencer and arbiter in front of the byte-addressed, big-endian data memory (40 bytes, word access). Shares the single memory port between two requesters: the pipeline MEM stage (cpu_*) and a debug/loader port (dbg_*). Also owns the memory-initialisation sweep, so the memory no longer needs its own init loop. Sits between the MEM stage / hazard unit and the data memory.

Parameters:
MEM_BYTES, 40, memory size in bytes; must be a multiple of 4.
INIT_VALUE, 32'h0000_0001, word written to every location by the init sweep.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start_init  in  1  pulse; begins the init sweep when the controller is in IDLE
init_busy  out  1  high while in INIT
init_done  out  1  one-cycle pulse after the last init write
cpu_req  in  1  MEM-stage access request
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, combinational from mem_rdata
cpu_stall  out  1  request not served this cycle; hazard unit freezes the pipe
dbg_req  in  1  debug request; held until granted
dbg_we  in  1  1 = write
dbg_addr  in  32  byte address
dbg_wdata  in  32  write data
dbg_gnt  out  1  debug access performed this cycle
dbg_rdata  out  32  registered read data
dbg_rvalid  out  1  dbg_rdata valid; one cycle after a granted read
addr_err  out  1  granted access was misaligned or out of range; access suppressed
mem_addr  out  32  to memory Address
mem_wdata  out  32  to memory WriteData
mem_write  out  1  to memory MemWrite
mem_read  out  1  to memory MemRead
mem_rdata  in  32  from memory ReadData

Behaviour:
- States: IDLE, INIT. Reset puts the block in IDLE. On reset all registered outputs are 0: init_busy, init_done, dbg_rvalid, dbg_rdata. The round-robin pointer resets to favour the CPU. The word counter resets to 0.
- IDLE with start_init=1:
  - No grants this cycle; cpu_stall = cpu_req.
  - Next state is INIT with counter = 0.
- INIT, one word per cycle:
  - Drives mem_write=1, mem_read=0, mem_addr=4*counter, mem_wdata=INIT_VALUE.
  - When counter = MEM_BYTES/4-1: return to IDLE and pulse init_done the next cycle.
  - A 10-word sweep takes 10 cycles.
  - All requests blocked: cpu_stall = cpu_req, dbg_gnt = 0.
  - start_init is ignored while in INIT.
- IDLE arbitration (combinational grant, memory access in the same cycle):
  - Only one requester active: that requester is granted.
  - Both requesting: grant the requester that did not win the last contended cycle.
  - The pointer updates only on contended cycles.
  - cpu_stall = cpu_req & ~cpu_grant.
- Granted access, normal case:
  - mem_addr, mem_wdata, mem_write = we, mem_read = ~we are taken from the winner.
  - With no grant: mem_write = 0, mem_read = 0.
- Granted access, error case (address not a multiple of 4, or address > MEM_BYTES-4):
  - mem_write and mem_read are forced to 0; addr_err = 1 that cycle.
  - The grant is still consumed: no stall, and dbg_gnt = 1.
  - A debug read that errors returns dbg_rvalid = 1 with dbg_rdata = 0.
- Read data paths:
  - cpu_rdata = mem_rdata when the CPU is granted a load, else 0.
  - A debug read grant registers mem_rdata into dbg_rdata and sets dbg_rvalid = 1 for exactly one cycle.
- rst mid-INIT aborts the sweep: IDLE, counter 0, no init_done pulse. Partially written words remain.
- The controller never issues a write and a read in the same cycle.

Decomposition:
- Shared package: state encoding (IDLE, INIT), WORD_BYTES = 4, and the requester index constants (CPU = 0, DBG = 1).
- One natural sub-module, dmem_rr_arb2: a two-requester round-robin arbiter holding the last-winner register.
- The init counter and FSM stay in dmem_ctrl.

Test Plan:
- Reset, then start_init pulse: 10 consecutive writes to addresses 0, 4, …, 36 with data 32'h1. init_done pulses in the cycle after address 36. Memory reads back 1 everywhere.
- During INIT, cpu_req=1 load of addr 8 → cpu_stall=1 for every INIT cycle. Served in the first IDLE cycle with mem_read=1, mem_addr=8.
- Both requesters held for 4 cycles, CPU store 0xAAAA to addr 4, dbg store 0x5555 to addr 12 → grants alternate CPU, DBG, CPU, DBG. cpu_stall=1 on DBG cycles.
- Debug read of addr 12 after a write of 0x5555 → dbg_gnt=1, then next cycle dbg_rvalid=1 and dbg_rdata=0x5555. dbg_rvalid is 0 the cycle after that.
- CPU store to addr 6, then to addr 40 → addr_err=1 and mem_write=0 both cycles. No stall. Memory unchanged.
- rst asserted on the 5th INIT cycle → IDLE next cycle, init_busy=0, no init_done. Words 0–3 hold 1, words 4–9 are unchanged. A fresh start_init performs a full 10-word sweep.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
//   dmem_state_e : controller state encoding (IDLE, INIT)
//   dmem_req_t   : one requester's access payload (we, addr, wdata)
//   addr_bad     : misaligned / out-of-range address check
package dmem_ctrl_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned WORD_BYTES = 4;

   // Requester indices into the two-bit request/grant vectors
   localparam int unsigned CPU = 0;
   localparam int unsigned DBG = 1;

   typedef enum logic {
      IDLE = 1'b0,
      INIT = 1'b1
   } dmem_state_e;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } dmem_req_t;

   // True when a word access at addr is not word-aligned or runs past the end
   function automatic logic addr_bad(input logic [XLEN-1:0] addr, input int unsigned mem_bytes);
      return (addr[1:0] != 2'b00) || (addr > XLEN'(mem_bytes - WORD_BYTES));
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the controller, its two requesters and the data memory.
//   cpu_* : MEM-stage access port (request, store data, load data, stall)
//   dbg_* : debug/loader port (request, grant, registered read data)
//   mem_* : single data-memory port driven by the controller
//   slave  modport : controller view
//   master modport : requesters + memory view
interface dmem_ctrl_if
   import dmem_ctrl_pkg::*;
   ();

   logic            cpu_req;
   logic            cpu_we;
   logic [XLEN-1:0] cpu_addr;
   logic [XLEN-1:0] cpu_wdata;
   logic [XLEN-1:0] cpu_rdata;
   logic            cpu_stall;

   logic            dbg_req;
   logic            dbg_we;
   logic [XLEN-1:0] dbg_addr;
   logic [XLEN-1:0] dbg_wdata;
   logic            dbg_gnt;
   logic [XLEN-1:0] dbg_rdata;
   logic            dbg_rvalid;

   logic            addr_err;

   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_write;
   logic            mem_read;
   logic [XLEN-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_gnt, dbg_rdata, dbg_rvalid,
      output addr_err,
      output mem_addr, mem_wdata, mem_write, mem_read,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_gnt, dbg_rdata, dbg_rvalid,
      input  addr_err,
      input  mem_addr, mem_wdata, mem_write, mem_read,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_rr_arb2.sv
// Two-requester round-robin arbiter with a combinational grant.
//   clk, rst : clock, synchronous active-high reset
//   en       : arbitration allowed this cycle (no grant when low)
//   req      : request vector, bit CPU / bit DBG
//   gnt_c    : one-hot grant (combinational)
// The last-winner register moves only on contended cycles; reset favours the CPU.
module dmem_rr_arb2
   import dmem_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt_c
);

   // 1 when the debug port won the most recent contended cycle
   logic last_dbg;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_dbg <= 1'b1;
      end else if (en && (&req)) begin
         last_dbg <= gnt_c[DBG];
      end
   end

   // Lone requester wins outright; on contention the previous loser wins
   always_comb begin
      gnt_c = 2'b00;
      if (en) begin
         if (&req) begin
            gnt_c[CPU] = last_dbg;
            gnt_c[DBG] = ~last_dbg;
         end else begin
            gnt_c = req;
         end
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory sequencer/arbiter: shares one word-wide memory port between the
// MEM stage and a debug/loader port, and runs the memory-initialisation sweep.
//   clk, rst   : clock, synchronous active-high reset
//   start_init : pulse, starts the sweep when IDLE
//   init_busy  : registered, high while sweeping
//   init_done  : registered, one-cycle pulse after the last sweep write
//   bus        : cpu_*, dbg_*, addr_err and mem_* signals (slave view)
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int unsigned     MEM_BYTES  = 40,
   parameter logic [XLEN-1:0] INIT_VALUE = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_init,
   output logic        init_busy,
   output logic        init_done,
   dmem_ctrl_if.slave  bus
);

   localparam int unsigned WORDS = MEM_BYTES / WORD_BYTES;
   localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

   dmem_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            init_busy_d, init_done_d;
   logic            dbg_rvalid_d;
   logic [XLEN-1:0] dbg_rdata_d;

   logic            arb_en_c;
   logic [1:0]      gnt_c;
   dmem_req_t       cpu_s, dbg_s, win_c;
   logic            win_bad_c;

   // Arbitration only in IDLE, outside reset, and not on the sweep-start cycle
   assign arb_en_c = ~rst & (state_q == IDLE) & ~start_init;

   dmem_rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (arb_en_c),
      .req   ({bus.dbg_req, bus.cpu_req}),
      .gnt_c (gnt_c)
   );

   assign cpu_s = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
   assign dbg_s = '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
   assign win_c = gnt_c[DBG] ? dbg_s : cpu_s;
   assign win_bad_c = addr_bad(win_c.addr, MEM_BYTES);

   assign bus.cpu_stall = bus.cpu_req & ~gnt_c[CPU];
   assign bus.dbg_gnt   = gnt_c[DBG];
   assign bus.cpu_rdata = (gnt_c[CPU] && !bus.cpu_we && !win_bad_c) ? bus.mem_rdata : '0;

   // State, sweep counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         init_busy      <= 1'b0;
         init_done      <= 1'b0;
         bus.dbg_rvalid <= 1'b0;
         bus.dbg_rdata  <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         init_busy      <= init_busy_d;
         init_done      <= init_done_d;
         bus.dbg_rvalid <= dbg_rvalid_d;
         bus.dbg_rdata  <= dbg_rdata_d;
      end
   end

   // Next state and memory-port drive; memory is left untouched while in reset
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      init_done_d   = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b0;
      bus.addr_err  = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (start_init) begin
                  state_d = INIT;
                  cnt_d   = '0;
               end else if (|gnt_c) begin
                  // A bad address still consumes the grant but never reaches memory
                  if (win_bad_c) begin
                     bus.addr_err = 1'b1;
                  end else begin
                     bus.mem_addr  = win_c.addr;
                     bus.mem_wdata = win_c.wdata;
                     bus.mem_write = win_c.we;
                     bus.mem_read  = ~win_c.we;
                  end
               end
            end
            INIT: begin
               bus.mem_write = 1'b1;
               bus.mem_addr  = XLEN'({cnt_q, 2'b00});
               bus.mem_wdata = INIT_VALUE;
               if (cnt_q == LAST_WORD) begin
                  state_d     = IDLE;
                  cnt_d       = '0;
                  init_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign init_busy_d = (state_d == INIT);

   // Debug read capture; an erroring read returns zero data
   always_comb begin
      dbg_rvalid_d = 1'b0;
      dbg_rdata_d  = bus.dbg_rdata;
      if (gnt_c[DBG] && !bus.dbg_we) begin
         dbg_rvalid_d = 1'b1;
         dbg_rdata_d  = win_bad_c ? '0 : bus.mem_rdata;
      end
   end

endmodule
